// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared definitions for the UART command decoder.
//               - Command opcodes.
//               - The 64-bit command word layout.
//               - Word and sync-preamble sizes.
//               - Read-path state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] RD_OPCODE   = 8'h00;
  localparam logic [7:0] WR_OPCODE   = 8'h01;
  localparam int         CMD_BYTES   = 8;
  localparam int         SYNC_FF_RUN = 15;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] addr;
    logic [31:0] data;
  } cmd_word_t;

  // The top-level read FSM uses IDLE/WAIT_ACK/SEND.
  // The serializer uses IDLE/SEND/GAP.
  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_WAIT_ACK = 2'd1,
    RD_SEND     = 2'd2,
    RD_GAP      = 2'd3
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_tx_serializer
// Description : Sends a 64-bit response word to the UART transmitter,
//               MSB byte first.
//               - One txstart pulse per byte, issued only when txready is 1.
//               - Each pulse is followed by a one-cycle gap, so the UART has
//                 time to drop txready.
// Ports       : clk, rst     - clock, async active-high reset
//               load, word   - start sending word (accepted when idle)
//               txready      - UART transmitter idle
//               txdata       - transmit byte, valid with txstart
//               txstart      - one-cycle transmit request
//               busy         - a word is being sent
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_tx_serializer
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] word,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txstart,
  output logic        busy
);

  rd_state_t   state, state_nxt;
  logic [63:0] word_q, word_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  txdata_nxt;
  logic        txstart_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RD_IDLE;
      word_q  <= '0;
      idx     <= '0;
      txdata  <= '0;
      txstart <= 1'b0;
    end else begin
      state   <= state_nxt;
      word_q  <= word_nxt;
      idx     <= idx_nxt;
      txdata  <= txdata_nxt;
      txstart <= txstart_nxt;
    end
  end

  // The next byte to send is always in word_q[63:56].
  // The word is shifted left by one byte in each gap cycle.
  always_comb begin
    state_nxt   = state;
    word_nxt    = word_q;
    idx_nxt     = idx;
    txdata_nxt  = txdata;
    txstart_nxt = 1'b0;
    case (state)
      RD_IDLE: begin
        if (load) begin
          word_nxt  = word;
          idx_nxt   = '0;
          state_nxt = RD_SEND;
        end
      end
      RD_SEND: begin
        if (txready) begin
          txstart_nxt = 1'b1;
          txdata_nxt  = word_q[63:56];
          state_nxt   = RD_GAP;
        end
      end
      RD_GAP: begin
        if (idx == 3'(CMD_BYTES - 1)) begin
          state_nxt = RD_IDLE;
        end else begin
          idx_nxt   = idx + 3'd1;
          word_nxt  = {word_q[55:0], 8'h00};
          state_nxt = RD_SEND;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign busy = (state != RD_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Assembles UART bytes into 64-bit command words
//               {opcode, addr, data}, MSB byte first.
//               - Resynchronises on 15 x 0xFF followed by 0x00.
//               - Issues write and read strobes.
//               - Sends read responses back through the UART transmitter.
// Ports       : clk, rst           - UART clock, async active-high reset
//               rxdata, rxvalid    - received byte and qualifier
//               txdata, txstart    - transmit byte and request
//               txready            - UART transmitter idle
//               wr_stb/addr/data   - register write strobe bus
//               rd_stb/addr        - register read strobe bus
//               rd_ack, rd_data    - read completion
//               bad_cmd_cnt        - saturating unknown-opcode count
//               overrun            - sticky: read dropped, response path busy
// Config      : UART_CMD_TIMEOUT_EN - discard a partial word after
//               TIMEOUT_CYCLES idle cycles
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxdata,
  input  logic        rxvalid,
  output logic [7:0]  txdata,
  output logic        txstart,
  input  logic        txready,
  output logic        wr_stb,
  output logic [23:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_stb,
  output logic [23:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic [7:0]  bad_cmd_cnt,
  output logic        overrun
);

  logic [63:0] shreg;
  logic [2:0]  bcnt;
  logic [3:0]  ffrun;
  rd_state_t   rd_state, rd_state_nxt;
  cmd_word_t   word_in;
  logic        sync_hit, word_done, rd_accept, timeout_hit;
  logic        tx_load, tx_busy;

  // The word as it will look once the current byte is shifted in.
  assign word_in   = {shreg[55:0], rxdata};
  assign sync_hit  = rxvalid && (rxdata == 8'h00) && (ffrun == 4'(SYNC_FF_RUN));
  assign word_done = rxvalid && !sync_hit && (bcnt == 3'(CMD_BYTES - 1));
  assign rd_accept = word_done && (word_in.opcode == RD_OPCODE) && (rd_state == RD_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;

  // Saturates at the limit. It stays there until the next byte clears it,
  // so the timeout fires only once per partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rxvalid) begin
      idle_cnt <= '0;
    end else if (bcnt != 3'd0 && idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = !rxvalid && (bcnt != 3'd0) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bcnt        <= '0;
      ffrun       <= '0;
      wr_stb      <= 1'b0;
      rd_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      bad_cmd_cnt <= '0;
      overrun     <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (timeout_hit) begin
        bcnt <= '0;
      end
      if (rxvalid) begin
        if (rxdata == 8'hFF) begin
          if (ffrun != 4'(SYNC_FF_RUN)) ffrun <= ffrun + 4'd1;
        end else begin
          ffrun <= '0;
        end

        if (sync_hit) begin
          bcnt <= '0;
        end else begin
          shreg <= word_in;
          bcnt  <= word_done ? 3'd0 : bcnt + 3'd1;
          if (word_done) begin
            if (word_in.opcode == WR_OPCODE) begin
              wr_stb  <= 1'b1;
              wr_addr <= word_in.addr;
              wr_data <= word_in.data;
            end else if (word_in.opcode == RD_OPCODE) begin
              if (rd_accept) begin
                rd_stb  <= 1'b1;
                rd_addr <= word_in.addr;
              end else begin
                overrun <= 1'b1;
              end
            end else if (bad_cmd_cnt != 8'hFF) begin
              bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

  // Read FSM.
  // WAIT_ACK is entered on the same edge that raises rd_stb, so an rd_ack
  // that coincides with rd_stb is still caught.
  // SEND covers the whole response transmission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    tx_load      = 1'b0;
    case (rd_state)
      RD_IDLE:     if (rd_accept) rd_state_nxt = RD_WAIT_ACK;
      RD_WAIT_ACK: begin
        if (rd_ack) begin
          tx_load      = 1'b1;
          rd_state_nxt = RD_SEND;
        end
      end
      RD_SEND:     if (!tx_busy) rd_state_nxt = RD_IDLE;
      default:     rd_state_nxt = RD_IDLE;
    endcase
  end

  uart_cmd_tx_serializer u_tx_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (tx_load),
    .word    ({RD_OPCODE, rd_addr, rd_data}),
    .txready (txready),
    .txdata  (txdata),
    .txstart (txstart),
    .busy    (tx_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Self-checking bench for uart_cmd_decoder.
//               - Directed and randomised command streams.
//               - Expected values come from a byte-level reference model.
//               - The bench also models the UART transmitter.
// Config      : honours UART_CMD_TIMEOUT_EN (TIMEOUT_CYCLES = 100)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  localparam int unsigned TO_CYC = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxdata;
  logic        rxvalid;
  logic [7:0]  txdata;
  logic        txstart;
  logic        txready;
  logic        wr_stb;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_stb;
  logic [23:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [7:0]  bad_cmd_cnt;
  logic        overrun;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .rxdata(rxdata), .rxvalid(rxvalid),
    .txdata(txdata), .txstart(txstart), .txready(txready),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .bad_cmd_cnt(bad_cmd_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for a random number of cycles per byte.
  int ucnt;
  always @(posedge clk or posedge rst) begin
    if (rst)               ucnt <= 0;
    else if (txstart)      ucnt <= int'($urandom_range(2, 6));
    else if (ucnt != 0)    ucnt <= ucnt - 1;
  end
  assign txready = (ucnt == 0);

  // Observation, sampled on the falling edge.
  int         obs_wr_cnt = 0;
  int         obs_rd_cnt = 0;
  int         hs_viol    = 0;
  logic [7:0] obs_tx_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_stb) obs_wr_cnt++;
      if (rd_stb) obs_rd_cnt++;
      if (txstart) begin
        obs_tx_q.push_back(txdata);
        if (!txready) hs_viol++;
      end
    end
  end

  // Reference model: bytes are collected into a queue, 8 bytes make a word.
  logic [7:0]  m_bytes[$];
  int          m_ff = 0;
  int          m_bad = 0;
  bit          m_overrun = 0;
  bit          m_busy = 0;
  int          m_wr_total = 0;
  int          m_rd_total = 0;
  logic [55:0] exp_wr_q[$];
  logic [23:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];

  function automatic void model_byte(input logic [7:0] b);
    logic [63:0] w;
    if (b == 8'h00 && m_ff >= 15) begin
      m_bytes.delete();
      m_ff = 0;
      return;
    end
    m_ff = (b == 8'hFF) ? ((m_ff < 15) ? m_ff + 1 : 15) : 0;
    m_bytes.push_back(b);
    if (m_bytes.size() == 8) begin
      w = '0;
      foreach (m_bytes[i]) w = {w[55:0], m_bytes[i]};
      m_bytes.delete();
      if (w[63:56] == 8'h01) begin
        exp_wr_q.push_back(w[55:0]);
        m_wr_total++;
      end else if (w[63:56] == 8'h00) begin
        if (m_busy) m_overrun = 1'b1;
        else begin
          exp_rd_q.push_back(w[55:32]);
          m_rd_total++;
          m_busy = 1'b1;
        end
      end else if (m_bad < 255) begin
        m_bad++;
      end
    end
  endfunction

  function automatic void model_reset();
    m_bytes.delete();
    m_ff = 0;
    m_bad = 0;
    m_overrun = 1'b0;
    m_busy = 1'b0;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxdata  = b;
    rxvalid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    rxvalid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && maxgap > 0) idle(int'($urandom_range(0, maxgap)));
      send_byte(w[63 - 8*i -: 8]);
    end
  endtask

  // Called in the cycle right after the last byte of a write word.
  task automatic check_write(input string tag);
    logic [55:0] e;
    e = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 56'hx;
    chk({tag, "_stb"}, 64'(wr_stb), 64'd1);
    chk({tag, "_addr"}, 64'(wr_addr), 64'(e[55:32]));
    chk({tag, "_data"}, 64'(wr_data), 64'(e[31:0]));
  endtask

  task automatic wait_tx(input int n, input string tag);
    int t;
    t = 0;
    while (obs_tx_q.size() < n && t < 3000) begin
      idle(1);
      t++;
    end
    chk({tag, "_tx_wait"}, 64'(t < 3000), 64'd1);
  endtask

  task automatic check_tx(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_txbyte%0d", tag, i),
          64'((obs_tx_q.size() != 0) ? obs_tx_q.pop_front() : 8'hx),
          64'((exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 8'hx));
    end
    obs_tx_q.delete();
    exp_tx_q.delete();
  endtask

  // Send a read command, answer it after ackdly cycles, then check the
  // transmitted response.
  task automatic do_read(input logic [23:0] a, input logic [31:0] d,
                         input int ackdly, input int gap, input string tag);
    logic [63:0] w;
    w = {8'h00, a, 32'($urandom)};
    send_word(w, gap);
    chk({tag, "_rd_stb"}, 64'(rd_stb), 64'd1);
    chk({tag, "_rd_addr"}, 64'(rd_addr),
        64'((exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 24'hx));
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(8'(a >> (8*(i-1))));
    exp_tx_q.delete();
    exp_tx_q.push_back(8'h00);
    exp_tx_q.push_back(a[23:16]);
    exp_tx_q.push_back(a[15:8]);
    exp_tx_q.push_back(a[7:0]);
    exp_tx_q.push_back(d[31:24]);
    exp_tx_q.push_back(d[23:16]);
    exp_tx_q.push_back(d[15:8]);
    exp_tx_q.push_back(d[7:0]);
    if (ackdly > 0) idle(ackdly);
    rd_ack  = 1'b1;
    rd_data = d;
    idle(1);
    rd_ack  = 1'b0;
    rd_data = 32'($urandom);
    wait_tx(8, tag);
    check_tx(tag);
    idle(6);
    m_busy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;
    int          r;

    rst = 1'b1; rxvalid = 1'b0; rxdata = 8'h00; rd_ack = 1'b0; rd_data = '0;
    idle(3);
    chk("rst_txstart", 64'(txstart), 64'd0);
    chk("rst_txdata", 64'(txdata), 64'd0);
    chk("rst_wr_stb", 64'(wr_stb), 64'd0);
    chk("rst_rd_stb", 64'(rd_stb), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_bad_cnt", 64'(bad_cmd_cnt), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    idle(2);

    // Basic write.
    send_word(64'h01_00000a_00000013, 0);
    check_write("wr1");
    idle(1);
    chk("wr1_stb_drop", 64'(wr_stb), 64'd0);

    // Basic read, rd_ack 3 cycles after rd_stb.
    do_read(24'h000009, 32'hdeadbeef, 3, 0, "rd1");

    // Resynchronisation after stray bytes.
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    repeat (15) send_byte(8'hFF);
    send_byte(8'h00);
    send_word(64'h01_000017_00e02281, 0);
    check_write("sync_wr");
    idle(1);
    chk("sync_bad_cnt", 64'(bad_cmd_cnt), 64'(m_bad));
    chk("sync_wr_total", 64'(obs_wr_cnt), 64'(m_wr_total));
    chk("sync_rd_total", 64'(obs_rd_cnt), 64'(m_rd_total));

    // Unknown opcode, then saturation.
    send_word(64'h7f_000000_00000000, 0);
    chk("bad_no_wr", 64'(wr_stb), 64'd0);
    chk("bad_no_rd", 64'(rd_stb), 64'd0);
    chk("bad_cnt1", 64'(bad_cmd_cnt), 64'(m_bad));
    repeat (300) send_word(64'h7f_000000_00000000, 0);
    idle(1);
    chk("bad_sat", 64'(bad_cmd_cnt), 64'd255);

    // Second read while the first response is still on the wire.
    w = {8'h00, 24'h0000a5, 32'h0};
    send_word(w, 0);
    chk("ovr_rd_stb", 64'(rd_stb), 64'd1);
    chk("ovr_rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
    idle(1);
    rd_ack = 1'b1; rd_data = 32'h13579bdf;
    idle(1);
    rd_ack = 1'b0;
    exp_tx_q.delete();
    exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'h00);
    exp_tx_q.push_back(8'h00); exp_tx_q.push_back(8'ha5);
    exp_tx_q.push_back(8'h13); exp_tx_q.push_back(8'h57);
    exp_tx_q.push_back(8'h9b); exp_tx_q.push_back(8'hdf);
    wait_tx(1, "ovr_first");
    send_word({8'h00, 24'h000077, 32'h0}, 0);
    chk("ovr_no_rd_stb", 64'(rd_stb), 64'd0);
    chk("ovr_flag", 64'(overrun), 64'(m_overrun));
    wait_tx(8, "ovr");
    check_tx("ovr");
    idle(6);
    m_busy = 1'b0;
    chk("ovr_rd_total", 64'(obs_rd_cnt), 64'(m_rd_total));

    // Reset in the middle of a word.
    send_byte(8'h01); send_byte(8'h22); send_byte(8'h33);
    rst = 1'b1;
    model_reset();
    idle(2);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_bad", 64'(bad_cmd_cnt), 64'd0);
    rst = 1'b0;
    idle(1);
    send_word(64'h01_abcdef_01234567, 0);
    check_write("post_rst_wr");
    idle(1);

    // Randomised traffic.
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        w = {8'h01, 24'($urandom), 32'($urandom)};
        send_word(w, 3);
        check_write($sformatf("rnd%0d_wr", k));
      end else if (r <= 7) begin
        w = {8'($urandom_range(2, 254)), 24'($urandom), 32'($urandom)};
        send_word(w, 3);
        chk($sformatf("rnd%0d_bad_nostb", k), 64'(wr_stb | rd_stb), 64'd0);
        chk($sformatf("rnd%0d_bad_cnt", k), 64'(bad_cmd_cnt), 64'(m_bad));
      end else begin
        do_read(24'($urandom), 32'($urandom), int'($urandom_range(0, 4)), 2,
                $sformatf("rnd%0d_rd", k));
      end
      idle(int'($urandom_range(0, 3)));
    end

`ifdef UART_CMD_TIMEOUT_EN
    // Partial word abandoned by the idle timeout.
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    idle(150);
    m_bytes.delete();
    send_word(64'h01_0000c3_cafef00d, 0);
    check_write("to_wr");
    idle(1);
    chk("to_stb_drop", 64'(wr_stb), 64'd0);
`endif

    idle(5);
    chk("final_wr_total", 64'(obs_wr_cnt), 64'(m_wr_total));
    chk("final_rd_total", 64'(obs_rd_cnt), 64'(m_rd_total));
    chk("final_handshake", 64'(hs_viol), 64'd0);
    chk("final_overrun", 64'(overrun), 64'(m_overrun));
    chk("final_bad_cnt", 64'(bad_cmd_cnt), 64'(m_bad));
    chk("final_tx_idle", 64'(obs_tx_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
